// File: rtl/ysyx_23060171_dmem_responder_pkg.sv
// Shared encodings for the data-memory responder: state codes, request
// field widths and the LFSR seed.
package ysyx_23060171_dmem_responder_pkg;

    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 32;
    localparam int MASK_W    = 8;
    localparam int MASK_USED = 4;

    typedef logic [1:0] state_t;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [3:0] LFSR_SEED = 4'b1001;

endpackage

// File: rtl/ysyx_23060171_dmem_responder_if.sv
// Request/response bus between the load/store unit (master) and the
// data-memory responder (slave).
interface ysyx_23060171_dmem_responder_if;
    import ysyx_23060171_dmem_responder_pkg::*;

    // A transfer occurs on a rising edge where valid and ready are both high.
    // Once valid is raised the payload stays stable until that edge; ready
    // never depends combinationally on valid.
    logic              req_valid;
    logic              req_ready;
    logic              req_wen;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [MASK_W-1:0] req_wmask;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_wen, req_addr, req_wdata, req_wmask, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_wen, req_addr, req_wdata, req_wmask, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

endinterface

// File: rtl/ysyx_23060171_lfsr4.sv
// 4-bit maximal LFSR (x^4+x^3+1) used for random response delay; only
// built when DMEM_RAND_DELAY_EN is defined.
`ifdef DMEM_RAND_DELAY_EN
module ysyx_23060171_lfsr4
    import ysyx_23060171_dmem_responder_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    output logic [1:0] lfsr_low
);

    logic [3:0] lfsr_q;
    logic [3:0] lfsr_d;

    always_comb begin
        lfsr_d = {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr_low = lfsr_q[1:0];

endmodule
`endif

// File: rtl/ysyx_23060171_dmem_responder.sv
// Data-memory responder: one request at a time, fixed (or, with
// DMEM_RAND_DELAY_EN, LFSR-randomised) delay, then a held response.
module ysyx_23060171_dmem_responder
    import ysyx_23060171_dmem_responder_pkg::*;
#(
    parameter int          DEPTH   = 1024,
    parameter logic [31:0] BASE    = 32'h8000_0000,
    parameter int          LATENCY = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    ysyx_23060171_dmem_responder_if.slave  bus,
    output logic [1:0]                     dbg_state
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(LATENCY + 4) + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              wen_q, wen_d;
    logic              err_q, err_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [3:0]        wmask_q, wmask_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              resp_err_q, resp_err_d;

    logic              mem_we;
    logic [CNT_W-1:0]  delay;
    logic [31:0]       off;
    logic              in_range;
    logic              unused_mask_hi;

    assign unused_mask_hi = ^bus.req_wmask[MASK_W-1:MASK_USED];

`ifdef DMEM_RAND_DELAY_EN
    logic [1:0] lfsr_low;

    ysyx_23060171_lfsr4 u_lfsr (
        .clk      (clk),
        .rst      (rst),
        .lfsr_low (lfsr_low)
    );

    assign delay = CNT_W'(LATENCY) + CNT_W'(lfsr_low);
`else
    assign delay = CNT_W'(LATENCY);
`endif

    // Subtraction wraps below BASE, so the lower-bound compare is kept explicit.
    assign off      = bus.req_addr - BASE;
    assign in_range = (bus.req_addr >= BASE) && ((off >> 2) < 32'(DEPTH));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        wen_d      = wen_q;
        err_d      = err_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        wmask_d    = wmask_q;
        rdata_d    = rdata_q;
        resp_err_d = resp_err_q;
        mem_we     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    wen_d   = bus.req_wen;
                    err_d   = !in_range;
                    idx_d   = off[IDX_W+1:2];
                    wdata_d = bus.req_wdata;
                    wmask_d = bus.req_wmask[MASK_USED-1:0];
                    cnt_d   = delay;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == CNT_W'(1)) begin
                    cnt_d      = '0;
                    state_d    = ST_RESP;
                    mem_we     = wen_q && !err_q;
                    rdata_d    = (wen_q || err_q) ? '0 : mem_q[idx_q];
                    resp_err_d = err_q;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (bus.resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            wen_q      <= 1'b0;
            err_q      <= 1'b0;
            idx_q      <= '0;
            wdata_q    <= '0;
            wmask_q    <= '0;
            rdata_q    <= '0;
            resp_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wen_q      <= wen_d;
            err_q      <= err_d;
            idx_q      <= idx_d;
            wdata_q    <= wdata_d;
            wmask_q    <= wmask_d;
            rdata_q    <= rdata_d;
            resp_err_q <= resp_err_d;
        end
    end

    // Storage is deliberately not reset; mem_we is derived from reset state.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (wmask_q[i]) begin
                    mem_q[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    assign bus.req_ready  = (state_q == ST_IDLE);
    assign bus.resp_valid = (state_q == ST_RESP);
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = resp_err_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_ysyx_23060171_dmem_responder.sv
// Directed bench for the data-memory responder; latency check widens to
// LAT..LAT+3 when DMEM_RAND_DELAY_EN is defined.
module tb_ysyx_23060171_dmem_responder;
    import ysyx_23060171_dmem_responder_pkg::*;

    localparam int          LAT  = 3;
    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam int          DEPTH = 1024;

    logic       clk;
    logic       rst;
    logic [1:0] dbg_state;
    int         n_pass;
    int         n_total;

    ysyx_23060171_dmem_responder_if bus ();

    ysyx_23060171_dmem_responder #(
        .DEPTH   (DEPTH),
        .BASE    (BASE),
        .LATENCY (LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic check_lat(input string tag, input int lat);
`ifdef DMEM_RAND_DELAY_EN
        check(tag, 32'(lat >= LAT && lat <= LAT + 3), 32'd1);
`else
        check(tag, 32'(lat), 32'(LAT));
`endif
    endtask

    // Called at a negedge in IDLE; returns at the negedge where resp_valid is seen.
    task automatic issue(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [7:0] wmask, output int lat);
        logic got;
        bus.req_valid = 1'b1;
        bus.req_wen   = wen;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_wmask = wmask;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        lat = 0;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (bus.resp_valid) got = 1'b1;
        end
        if (!got) check("resp_timeout", 32'(got), 32'd1);
    endtask

    task automatic ack(output logic [31:0] rdata, output logic err);
        rdata = bus.resp_rdata;
        err   = bus.resp_err;
        bus.resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.resp_ready = 1'b0;
        check("req_ready_after_resp", 32'(bus.req_ready), 32'd1);
    endtask

    task automatic txn(input string tag, input logic wen, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [7:0] wmask,
                       input logic [31:0] exp_rdata, input logic exp_err);
        int          lat;
        logic [31:0] rdata;
        logic        err;
        issue(wen, addr, wdata, wmask, lat);
        ack(rdata, err);
        check_lat({tag, "_lat"}, lat);
        check({tag, "_rdata"}, rdata, exp_rdata);
        check({tag, "_err"}, 32'(err), 32'(exp_err));
    endtask

    initial begin
        int          lat;
        logic [31:0] rdata;
        logic        err;
        n_pass = 0;
        n_total = 0;
        rst = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_wen    = 1'b0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.req_wmask  = '0;
        bus.resp_ready = 1'b0;

        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_rdata", bus.resp_rdata, 32'd0);
        check("rst_err", 32'(bus.resp_err), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));

        txn("wr_full", 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 8'h0F, 32'h0, 1'b0);
        txn("rd_full", 1'b0, 32'h8000_0010, 32'h0, 8'h00, 32'hDEAD_BEEF, 1'b0);
        txn("wr_byte1", 1'b1, 32'h8000_0010, 32'h0000_AA00, 8'h02, 32'h0, 1'b0);
        txn("rd_byte1", 1'b0, 32'h8000_0012, 32'h0, 8'h00, 32'hDEAD_AAEF, 1'b0);
        txn("wr_mask0", 1'b1, 32'h8000_0010, 32'h1234_5678, 8'hF0, 32'h0, 1'b0);
        txn("rd_mask0", 1'b0, 32'h8000_0010, 32'h0, 8'h00, 32'hDEAD_AAEF, 1'b0);

        txn("wr_base", 1'b1, BASE, 32'h0, 8'h0F, 32'h0, 1'b0);
        txn("wr_last", 1'b1, BASE + 32'(4 * DEPTH - 4), 32'hCAFE_F00D, 8'h0F, 32'h0, 1'b0);
        txn("wr_over", 1'b1, BASE + 32'(4 * DEPTH), 32'hFFFF_FFFF, 8'h0F, 32'h0, 1'b1);
        txn("rd_below", 1'b0, 32'h7FFF_FFFC, 32'h0, 8'h00, 32'h0, 1'b1);
        txn("rd_over", 1'b0, BASE + 32'(4 * DEPTH), 32'h0, 8'h00, 32'h0, 1'b1);
        txn("rd_base", 1'b0, BASE, 32'h0, 8'h00, 32'h0, 1'b0);
        txn("rd_last", 1'b0, BASE + 32'(4 * DEPTH - 4), 32'h0, 8'h00, 32'hCAFE_F00D, 1'b0);

        // Response held back; a request presented meanwhile must be ignored.
        issue(1'b0, 32'h8000_0010, 32'h0, 8'h00, lat);
        check_lat("hold_lat", lat);
        bus.req_valid = 1'b1;
        bus.req_wen   = 1'b1;
        bus.req_addr  = 32'h8000_0010;
        bus.req_wdata = 32'h0;
        bus.req_wmask = 8'h0F;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_valid", 32'(bus.resp_valid), 32'd1);
            check("hold_rdata", bus.resp_rdata, 32'hDEAD_AAEF);
            check("hold_req_ready", 32'(bus.req_ready), 32'd0);
        end
        bus.req_valid = 1'b0;
        ack(rdata, err);
        check("hold_ack_rdata", rdata, 32'hDEAD_AAEF);
        txn("rd_after_hold", 1'b0, 32'h8000_0010, 32'h0, 8'h00, 32'hDEAD_AAEF, 1'b0);

        // Reset while a write waits: write must be dropped.
        bus.req_valid = 1'b1;
        bus.req_wen   = 1'b1;
        bus.req_addr  = 32'h8000_0010;
        bus.req_wdata = 32'h1111_1111;
        bus.req_wmask = 8'h0F;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        check("mid_state_wait", 32'(dbg_state), 32'(ST_WAIT));
        rst = 1'b1;
        #1;
        check("mid_rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("mid_rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("mid_rst_rdata", bus.resp_rdata, 32'd0);
        check("mid_rst_err", 32'(bus.resp_err), 32'd0);
        check("mid_rst_state", 32'(dbg_state), 32'(ST_IDLE));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        txn("rd_after_rst", 1'b0, 32'h8000_0010, 32'h0, 8'h00, 32'hDEAD_AAEF, 1'b0);

        for (int k = 0; k < 16; k++) begin
            issue(1'b0, BASE + 32'(4 * DEPTH - 4), 32'h0, 8'h00, lat);
            check_lat("loop_lat", lat);
            ack(rdata, err);
            check("loop_rdata", rdata, 32'hCAFE_F00D);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
